// File: rtl/nrisc_pc_pkg.sv
// Shared next-PC definitions: source encoding and a width-limited wrapping adder.
// Purely combinational helpers; no state and no flow control.
package nrisc_pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_CALL,
    SRC_RET
  } next_src_e;

  localparam int unsigned ADDR_MAX_W = 64;

  // Callers zero-extend operands and truncate the result back to their own width.
  function automatic logic [ADDR_MAX_W-1:0] wrap_add(
    input logic [ADDR_MAX_W-1:0] a,
    input logic [ADDR_MAX_W-1:0] b,
    input int unsigned           width
  );
    logic [ADDR_MAX_W-1:0] mask;
    mask = (width >= ADDR_MAX_W) ? '1 : ((ADDR_MAX_W'(1) << width) - ADDR_MAX_W'(1));
    return (a + b) & mask;
  endfunction

endpackage

// File: rtl/next_pc_unit_ras_stack.sv
// Circular return-address stack: top pointer plus count, push overwrites oldest when full.
// Push/pop take effect on the next clk edge; top_data is a combinational read of the top entry.
module ras_stack #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full     = (count_q == CNT_W'(RAS_DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign top_data = mem_q[top_ptr_q];

  // Pointer wraps naturally because RAS_DEPTH is a power of two.
  always_comb begin
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    if (push) begin
      top_ptr_d = top_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr_d = top_ptr_q - PTR_W'(1);
      count_d   = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[top_ptr_d] <= push_data;
  end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter with priority next-PC select (ret > call > jump > taken branch > seq) and RAS.
// New PC one clk edge after the select is sampled; stall holds PC, RAS and sticky flags.
module next_pc_unit #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0]  RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        jump,
  input  logic                        call,
  input  logic                        ret,
  input  logic                        branch,
  input  logic                        branch_taken,
  input  logic [WIDTH-1:0]            jump_target,
  input  logic [WIDTH-1:0]            branch_offset,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus1,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_overflow,
  output logic                        ras_underflow
);

  import nrisc_pc_pkg::*;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop, ras_full, ras_empty;
  next_src_e        src;

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign pc_plus1      = WIDTH'(wrap_add(ADDR_MAX_W'(pc_q), ADDR_MAX_W'(1), WIDTH));
  assign br_target     = WIDTH'(wrap_add(ADDR_MAX_W'(pc_q), ADDR_MAX_W'(branch_offset), WIDTH));

  always_comb begin
    src = SRC_SEQ;
    if (ret)                         src = SRC_RET;
    else if (call)                   src = SRC_CALL;
    else if (jump)                   src = SRC_JMP;
    else if (branch && branch_taken) src = SRC_BR;
  end

  always_comb begin
    pc_d     = pc_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      case (src)
        SRC_RET: begin
          // Return on an empty stack falls through sequentially and is flagged.
          if (ras_empty) begin
            pc_d  = pc_plus1;
            unf_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
        end
        SRC_CALL: begin
          pc_d     = jump_target;
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
        end
        SRC_JMP: pc_d = jump_target;
        SRC_BR:  pc_d = br_target;
        default: pc_d = pc_plus1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus1),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: directed scenarios then random selects against a queue-based model.
module tb_next_pc_unit;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int M     = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic         branch = 1'b0, branch_taken = 1'b0;
  logic [W-1:0] jump_target = '0, branch_offset = '0;
  logic [W-1:0] pc, pc_plus1;
  logic [2:0]   ras_count;
  logic         ras_overflow, ras_underflow;

  next_pc_unit #(.WIDTH(W), .RAS_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .jump          (jump),
    .call          (call),
    .ret           (ret),
    .branch        (branch),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int cnt;
    bit ovf;
    bit unf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  event mon_ev;

  // Reference model: PC as an integer, RAS as a plain list of return addresses.
  int   m_pc = 0;
  int   m_ras[$];
  bit   m_ovf = 0, m_unf = 0;
  bit   drv_rst = 1'b1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t cur_exp();
    exp_t e;
    e.pc  = m_pc;
    e.cnt = m_ras.size();
    e.ovf = m_ovf;
    e.unf = m_unf;
    return e;
  endfunction

  function automatic void model_reset();
    m_pc = 0;
    m_ras.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic void model_step(input bit s, j, c, r, b, bt, input int tgt, off);
    if (s) return;
    if (r) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = (m_pc + 1) & M;
        m_unf = 1;
      end
    end else if (c) begin
      m_ras.push_back((m_pc + 1) & M);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1;
      end
      m_pc = tgt;
    end else if (j) m_pc = tgt;
    else if (b && bt) m_pc = (m_pc + off) & M;
    else m_pc = (m_pc + 1) & M;
  endfunction

  task automatic cyc(input bit s, j, c, r, b, bt, input logic [W-1:0] tgt, off);
    @(negedge clk);
    rst = drv_rst;
    stall = s; jump = j; call = c; ret = r; branch = b; branch_taken = bt;
    jump_target = tgt; branch_offset = off;
    if (drv_rst) model_reset();
    else model_step(s, j, c, r, b, bt, int'(tgt), int'(off));
    exp_q.push_back(cur_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic jmp(input logic [W-1:0] t);
    cyc(0, 1, 0, 0, 0, 0, t, 8'h00);
  endtask

  task automatic do_call(input logic [W-1:0] t);
    cyc(0, 0, 1, 0, 0, 0, t, 8'h00);
  endtask

  task automatic do_ret();
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for clk.
  task automatic async_reset();
    @(posedge clk);
    #2;
    drv_rst = 1'b1;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(cur_exp());
    #1 -> mon_ev;
    #1;
  endtask

  task automatic sync_reset();
    drv_rst = 1'b1;
    idle(1);
    drv_rst = 1'b0;
  endtask

  always @(posedge clk) begin
    #1 -> mon_ev;
  end

  initial begin
    exp_t e;
    forever begin
      @(mon_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(pc), e.pc);
        chk("pc_plus1", int'(pc_plus1), (e.pc + 1) & M);
        chk("ras_count", int'(ras_count), e.cnt);
        chk("ras_overflow", int'(ras_overflow), int'(e.ovf));
        chk("ras_underflow", int'(ras_underflow), int'(e.unf));
      end
    end
  end

  initial begin
    bit s, j, c, r, b, bt;
    #2;
    exp_q.push_back(cur_exp());
    -> mon_ev;
    idle(1);
    drv_rst = 1'b0;

    // Mid-run async reset, then sequential counting.
    jmp(8'h37);
    async_reset();
    idle(1);
    drv_rst = 1'b0;
    idle(3);

    // Jump, taken backward branch, untaken branch.
    jmp(8'h11);
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'hFD);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'hFD);

    // Call and return.
    jmp(8'h20);
    do_call(8'h40);
    idle(2);
    do_ret();

    // Overflow then underflow.
    sync_reset();
    do_call(8'h10);
    do_call(8'h20);
    do_call(8'h30);
    do_call(8'h50);
    do_call(8'h60);
    for (int i = 0; i < 5; i++) do_ret();

    // Priority and stall.
    sync_reset();
    jmp(8'h04);
    do_call(8'h70);
    cyc(0, 1, 1, 1, 1, 1, 8'h99, 8'h07);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0, 8'hAA, 8'h00);
    cyc(1, 0, 0, 1, 1, 1, 8'h00, 8'h05);

    // Address wrap.
    jmp(8'hFF);
    idle(1);
    jmp(8'h02);
    cyc(0, 0, 0, 0, 1, 1, 8'h00, 8'hFC);

    // Randomized mixes of every select.
    for (int i = 0; i < 800; i++) begin
      drv_rst = ($urandom_range(0, 120) == 0);
      s  = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 4) == 0);
      c  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 2) == 0);
      bt = $urandom_range(0, 1) == 1;
      cyc(s, j, c, r, b, bt, W'($urandom), W'($urandom));
      drv_rst = 1'b0;
    end
    idle(1);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
